// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the control FSM and the multi-cycle ALU.
// master: drives i_start, i_aluControl, i_srcA, i_srcB and observes the results.
// slave: the ALU; drives o_busy, o_done, o_result, o_zero, o_overflow, o_hi, o_lo.
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic             i_start;
  logic [3:0]       i_aluControl;
  logic [WIDTH-1:0] i_srcA;
  logic [WIDTH-1:0] i_srcB;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;
  logic             o_overflow;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_aluControl, i_srcA, i_srcB,
    input  o_busy, o_done, o_result, o_zero, o_overflow, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_aluControl, i_srcA, i_srcB,
    output o_busy, o_done, o_result, o_zero, o_overflow, o_hi, o_lo
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle arithmetic/logic plus iterative MULTU/DIVU into HI/LO.
// Latency: 1 cycle for single-cycle ops and DIVU by zero, WIDTH+1 cycles for MULTU/DIVU.
// Backpressure: o_busy high while iterating; i_start during o_busy is dropped, not queued.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport of alu_multicycle_if).
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  alu_multicycle_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             op_div;     // running op: 1 = DIVU, 0 = MULTU
  logic [WIDTH-1:0] opnd_b;     // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier shifting out / dividend shifting into quotient
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             accept;

  assign a      = bus.i_srcA;
  assign b      = bus.i_srcB;
  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = (state != RUN) && bus.i_start;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.i_aluControl)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_LUI:  alu_res = {b[15:0], {(WIDTH-16){1'b0}}};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One iteration of either algorithm. Multiply adds the multiplicand when the
  // multiplier LSB is set and shifts the 2*WIDTH+1 product right. Divide shifts the
  // next dividend bit into the remainder and keeps the difference only if it did not
  // borrow (top bit of the WIDTH+1 difference clear).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (op_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      op_div         <= 1'b0;
      opnd_b         <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      cnt            <= '0;
      bus.o_result   <= '0;
      bus.o_zero     <= 1'b1;
      bus.o_overflow <= 1'b0;
      bus.o_hi       <= '0;
      bus.o_lo       <= '0;
    end else begin
      case (state)
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state          <= DONE;
            bus.o_hi       <= step_hi;
            bus.o_lo       <= step_lo;
            bus.o_result   <= step_lo;
            bus.o_zero     <= (step_lo == '0);
            bus.o_overflow <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (bus.i_aluControl == OP_MULTU ||
                (bus.i_aluControl == OP_DIVU && b != '0)) begin
              state  <= RUN;
              op_div <= (bus.i_aluControl == OP_DIVU);
              opnd_b <= b;
              acc_hi <= '0;
              acc_lo <= a;
              cnt    <= '0;
            end else if (bus.i_aluControl == OP_DIVU) begin
              // Divide by zero: no iteration, defined HI/LO values.
              state          <= DONE;
              bus.o_hi       <= a;
              bus.o_lo       <= '1;
              bus.o_result   <= '1;
              bus.o_zero     <= 1'b0;
              bus.o_overflow <= 1'b0;
            end else begin
              state          <= DONE;
              bus.o_result   <= alu_res;
              bus.o_zero     <= (alu_res == '0);
              bus.o_overflow <= alu_ovf;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_busy = (state == RUN);
  assign bus.o_done = (state == DONE);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, MULTU/DIVU timing, ignored
// start while busy, streaming, and asynchronous reset in the middle of a divide.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_multicycle;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request held for exactly one edge; returns in cycle 1 after acceptance.
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.i_start      = 1'b1;
    bus.i_aluControl = code;
    bus.i_srcA       = a;
    bus.i_srcB       = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Count cycles (issue cycle = 1) until o_done; optionally inject an ADD at one cycle.
  task automatic wait_done(input int inject, output int cycles, output int busy_cycles);
    cycles = 1;
    busy_cycles = 0;
    while (!bus.o_done && cycles < 100) begin
      if (bus.o_busy) busy_cycles++;
      if (cycles == inject) begin
        bus.i_start = 1'b1; bus.i_aluControl = 4'b0000; bus.i_srcA = 32'd1; bus.i_srcB = 32'd1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++; if (bus.o_result !== 32'd0) $display("FAIL reset_result got %h want 0", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_zero !== 1'b1) $display("FAIL reset_zero got %b want 1", bus.o_zero); else pass_cnt++;
    total_cnt++; if (bus.o_overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.o_overflow); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_busy); else pass_cnt++;
    total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_done); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd0) $display("FAIL reset_hi got %h want 0", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'd0) $display("FAIL reset_lo got %h want 0", bus.o_lo); else pass_cnt++;
  endtask

  task automatic test_add_overflow;
    issue(4'b0000, 32'h7FFFFFFF, 32'd1);
    total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL add_done got %b want 1", bus.o_done); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'h80000000) $display("FAIL add_result got %h want 80000000", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_overflow !== 1'b1) $display("FAIL add_ovf got %b want 1", bus.o_overflow); else pass_cnt++;
    total_cnt++; if (bus.o_zero !== 1'b0) $display("FAIL add_zero got %b want 0", bus.o_zero); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL add_busy got %b want 0", bus.o_busy); else pass_cnt++;
    issue(4'b0001, 32'h7FFFFFFF, 32'd1);
    total_cnt++; if (bus.o_result !== 32'h80000000) $display("FAIL addu_result got %h want 80000000", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_overflow !== 1'b0) $display("FAIL addu_ovf got %b want 0", bus.o_overflow); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL add_done_pulse got %b want 0", bus.o_done); else pass_cnt++;
  endtask

  task automatic test_sub_slt_lui;
    issue(4'b0010, 32'h1234, 32'h1234);
    total_cnt++; if (bus.o_result !== 32'd0) $display("FAIL sub_result got %h want 0", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_zero !== 1'b1) $display("FAIL sub_zero got %b want 1", bus.o_zero); else pass_cnt++;
    total_cnt++; if (bus.o_overflow !== 1'b0) $display("FAIL sub_ovf got %b want 0", bus.o_overflow); else pass_cnt++;
    issue(4'b0010, 32'h80000000, 32'd1);
    total_cnt++; if (bus.o_result !== 32'h7FFFFFFF) $display("FAIL sub_ovf_result got %h want 7fffffff", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_overflow !== 1'b1) $display("FAIL sub_ovf_flag got %b want 1", bus.o_overflow); else pass_cnt++;
    issue(4'b1010, 32'hFFFFFFFF, 32'd1);
    total_cnt++; if (bus.o_result !== 32'd1) $display("FAIL slt_result got %h want 1", bus.o_result); else pass_cnt++;
    issue(4'b1010, 32'd1, 32'hFFFFFFFF);
    total_cnt++; if (bus.o_result !== 32'd0) $display("FAIL slt_false got %h want 0", bus.o_result); else pass_cnt++;
    issue(4'b1001, 32'h55555555, 32'h0000ABCD);
    total_cnt++; if (bus.o_result !== 32'hABCD0000) $display("FAIL lui_result got %h want abcd0000", bus.o_result); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    int cyc, bcyc;
    issue(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, cyc, bcyc);
    total_cnt++; if (cyc !== 33) $display("FAIL multu_latency got %0d want 33", cyc); else pass_cnt++;
    total_cnt++; if (bcyc !== 32) $display("FAIL multu_busy_cycles got %0d want 32", bcyc); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got %h want fffffffe", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'h00000001) $display("FAIL multu_lo got %h want 00000001", bus.o_lo); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'h00000001) $display("FAIL multu_result got %h want 00000001", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL multu_busy_at_done got %b want 0", bus.o_busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL multu_done_pulse got %b want 0", bus.o_done); else pass_cnt++;
  endtask

  task automatic test_divu;
    int cyc, bcyc;
    issue(4'b1101, 32'd100, 32'd7);
    wait_done(0, cyc, bcyc);
    total_cnt++; if (cyc !== 33) $display("FAIL divu_latency got %0d want 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'd14) $display("FAIL divu_lo got %0d want 14", bus.o_lo); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd2) $display("FAIL divu_hi got %0d want 2", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'd14) $display("FAIL divu_result got %0d want 14", bus.o_result); else pass_cnt++;
    @(posedge clk); #1;
    issue(4'b1101, 32'd5, 32'd0);
    total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL div0_done got %b want 1", bus.o_done); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL div0_busy got %b want 0", bus.o_busy); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd5) $display("FAIL div0_hi got %h want 5", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'hFFFFFFFF) $display("FAIL div0_lo got %h want ffffffff", bus.o_lo); else pass_cnt++;
  endtask

  // Held start: each op completes one cycle after its request; unknown code gives 0.
  task automatic test_back_to_back;
    logic [3:0]  codes [4] = '{4'b0100, 4'b0101, 4'b0110, 4'b0011};
    logic [31:0] exp   [4] = '{32'h0000F000, 32'h0000FFF0, 32'hFFFF000F, 32'h00000000};
    bus.i_srcA = 32'h0000F0F0;
    bus.i_srcB = 32'h0000FF00;
    bus.i_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_aluControl = codes[i];
      @(posedge clk); #1;
      total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL stream_done[%0d] got %b want 1", i, bus.o_done); else pass_cnt++;
      total_cnt++; if (bus.o_result !== exp[i]) $display("FAIL stream_result[%0d] got %h want %h", i, bus.o_result, exp[i]); else pass_cnt++;
    end
    bus.i_start = 1'b0;
    total_cnt++; if (bus.o_zero !== 1'b1) $display("FAIL unknown_zero got %b want 1", bus.o_zero); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd5) $display("FAIL unknown_hi_kept got %h want 5", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'hFFFFFFFF) $display("FAIL unknown_lo_kept got %h want ffffffff", bus.o_lo); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL stream_end_done got %b want 0", bus.o_done); else pass_cnt++;
  endtask

  // MULTU accepted straight from DONE of a single-cycle op, ADD injected at cycle 10.
  task automatic test_start_while_busy;
    int cyc, bcyc, dones;
    issue(4'b0001, 32'd2, 32'd2);
    issue(4'b1100, 32'h00010000, 32'h00030000);
    total_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL from_done_busy got %b want 1", bus.o_busy); else pass_cnt++;
    wait_done(10, cyc, bcyc);
    total_cnt++; if (cyc !== 33) $display("FAIL ignore_latency got %0d want 33", cyc); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd3) $display("FAIL ignore_hi got %h want 3", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'd0) $display("FAIL ignore_lo got %h want 0", bus.o_lo); else pass_cnt++;
    total_cnt++; if (bus.o_zero !== 1'b1) $display("FAIL ignore_zero got %b want 1", bus.o_zero); else pass_cnt++;
    dones = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.o_done) dones++;
    end
    total_cnt++; if (dones !== 1) $display("FAIL ignore_done_pulses got %0d want 1", dones); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    issue(4'b1101, 32'hFFFFFFFF, 32'd3);
    repeat (14) begin @(posedge clk); #1; end
    total_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL midrun_busy got %b want 1", bus.o_busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL arst_busy got %b want 0", bus.o_busy); else pass_cnt++;
    total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL arst_done got %b want 0", bus.o_done); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'd0) $display("FAIL arst_result got %h want 0", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_zero !== 1'b1) $display("FAIL arst_zero got %b want 1", bus.o_zero); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd0) $display("FAIL arst_hi got %h want 0", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'd0) $display("FAIL arst_lo got %h want 0", bus.o_lo); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0000, 32'd2, 32'd3);
    total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL post_rst_done got %b want 1", bus.o_done); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'd5) $display("FAIL post_rst_result got %h want 5", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_hi !== 32'd0) $display("FAIL post_rst_hi got %h want 0", bus.o_hi); else pass_cnt++;
    total_cnt++; if (bus.o_lo !== 32'd0) $display("FAIL post_rst_lo got %h want 0", bus.o_lo); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_aluControl = 4'b0000;
    bus.i_srcA = '0;
    bus.i_srcB = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_overflow();
    test_sub_slt_lui();
    test_multu();
    test_divu();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder, plus two 32-bit operands. It produces a registered result, a zero flag and an overflow flag. It extends the code set with iterative unsigned multiply and divide that write a HI/LO register pair, and uses a start/busy/done handshake so the control FSM can stall while a multi-cycle operation runs.

## Interface
- WIDTH, 32, operand/result width; multiply/divide iteration count equals WIDTH.

- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  request: sample code and operands this edge
- i_aluControl  in  4  operation code
- i_srcA  in  WIDTH  operand A (rs)
- i_srcB  in  WIDTH  operand B (rt or extended immediate)
- o_busy  out  1  multi-cycle operation in progress; new requests ignored
- o_done  out  1  one-cycle pulse: outputs updated this cycle
- o_result  out  WIDTH  registered result
- o_zero  out  1  registered (o_result == 0)
- o_overflow  out  1  registered signed overflow (ADD/SUB only)
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register

## Operation
- Codes:
  - ADD 0000: A+B, overflow flagged.
  - ADDU 0001: A+B, overflow always 0.
  - SUB 0010: A−B, overflow flagged.
  - AND 0100, OR 0101, NOR 0110: bitwise.
  - SLT 1010: signed A<B → 1, else 0.
  - LUI 1001: {B[15:0],16'h0000}.
  - MULTU 1100: {HI,LO} = A*B unsigned.
  - DIVU 1101: LO = A/B, HI = A%B unsigned.
  - Any other code: result 0, overflow 0, HI/LO unchanged.
- Overflow for ADD: operand signs equal and result sign differs. For SUB: operand signs differ and result sign differs from A.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with i_start and a single-cycle code: go to DONE; load o_result, o_zero and o_overflow.
  - IDLE/DONE with i_start and MULTU, or DIVU with B≠0: latch operands, clear iteration counter, go to RUN.
  - IDLE/DONE with i_start and DIVU with B=0: go to DONE; HI=A, LO=all ones; no RUN.
  - IDLE/DONE without i_start: go to IDLE; DONE lasts exactly one cycle.
  - RUN: one iteration per cycle.
    - MULTU: shift-add, one multiplier bit per cycle, LSB first.
    - DIVU: restoring, one quotient bit per cycle, MSB first.
    - After WIDTH iterations: write HI/LO, go to DONE.
- For MULTU and DIVU, o_result = final LO; o_zero follows it; o_overflow = 0.
- o_busy = (state == RUN). o_done = (state == DONE).
- i_start while o_busy is ignored: no queuing, no effect on the running operation.
- Operands and code are captured at the accept edge. Input changes during RUN have no effect.
- Outputs hold their last value until the next DONE. HI/LO change only on MULTU/DIVU completion.
- Reset (any time, including mid-RUN):
  - State = IDLE.
  - o_result, o_hi and o_lo all 0; o_zero = 1; o_overflow, o_busy and o_done all 0.
  - Internal accumulators and counter cleared; the aborted operation is lost.

## Timing
- Start accepted at edge 0.
- Single-cycle ops and DIVU-by-zero: o_done high during cycle 1, with outputs valid in the same cycle.
- MULTU/DIVU: o_busy high during cycles 1..WIDTH (32 cycles). o_done and HI/LO/result valid during cycle WIDTH+1 (33).
- Streaming: i_start may be held every cycle for single-cycle ops; o_done then stays high and each result appears one cycle after its request.
- A start accepted in DONE begins the next operation at that same edge. No idle bubble is required.
- Iteration counter width: clog2(WIDTH)+1. Counter terminates at WIDTH exactly, with no wrap and no extra iteration.

## Test plan
- ADD, A=0x7FFFFFFF, B=1 → cycle 1: o_done=1, result 0x80000000, overflow=1, zero=0. ADDU with the same operands → overflow=0.
- SUB, A=B=0x1234 → result 0, zero=1, overflow=0. SLT, A=0xFFFFFFFF, B=1 → result 1. LUI, B=0xABCD → result 0xABCD0000.
- MULTU, A=B=0xFFFFFFFF → o_busy cycles 1–32; cycle 33: HI=0xFFFFFFFE, LO=0x00000001, o_done pulse for one cycle.
- DIVU, A=100, B=7 → cycle 33: LO=14, HI=2. DIVU, A=5, B=0 → cycle 1: HI=5, LO=0xFFFFFFFF, no busy.
- i_start with ADD pulsed at cycle 10 of a running MULTU → ignored; the MULTU result is unaffected and exactly one o_done pulse occurs.
- i_rst_n low at cycle 15 of a DIVU → all outputs at reset values immediately (async). After release, a new ADD completes normally and HI/LO read 0.
